// File: rtl/ucaspian_pkg.sv
// Shared widths and synapse-table entry layout for the uCaspian blocks.
package ucaspian_pkg;

  localparam int unsigned SYN_COUNT  = 4096;
  localparam int unsigned SYN_ADDR_W = 12;
  localparam int unsigned NEURON_W   = 8;
  localparam int unsigned WEIGHT_W   = 8;
  localparam int unsigned SYN_DATA_W = NEURON_W + WEIGHT_W;

  // config_byte selectors for the staged table-load protocol
  localparam logic [2:0] CFG_BYTE_CLR    = 3'd1;
  localparam logic [2:0] CFG_BYTE_TARGET = 3'd2;
  localparam logic [2:0] CFG_BYTE_WEIGHT = 3'd3;

  typedef struct packed {
    logic        [NEURON_W-1:0] target;
    logic signed [WEIGHT_W-1:0] weight;
  } syn_entry_t;

endpackage

// File: rtl/dp_ram_16x4096.sv
// Simple dual-port 16x4096 table: one write port, one registered read port.
// Contents are not reset; read data holds when rd_en is low.
module dp_ram_16x4096
  import ucaspian_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [SYN_ADDR_W-1:0] wr_addr,
  input  logic [SYN_DATA_W-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [SYN_ADDR_W-1:0] rd_addr,
  output logic [SYN_DATA_W-1:0] rd_data
);

  logic [SYN_DATA_W-1:0] mem_q [SYN_COUNT];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/ucaspian_synapse.sv
// Synapse stage: walks an inclusive synapse range through the table and emits one
// (target, weight) charge per entry to the dendrite. Macro UCASPIAN_SYN_SKIP_ZERO_EN drops weight-0 entries.
module ucaspian_synapse
  import ucaspian_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_config,
  output logic                       clear_done,
  input  logic [SYN_ADDR_W-1:0]      config_addr,
  input  logic [11:0]                config_value,
  input  logic [2:0]                 config_byte,
  input  logic                       config_enable,
  input  logic                       next_step,
  output logic                       step_done,
  input  logic [SYN_ADDR_W-1:0]      syn_start,
  input  logic [SYN_ADDR_W-1:0]      syn_end,
  input  logic                       syn_vld,
  output logic                       syn_rdy,
  output logic [NEURON_W-1:0]        dend_addr,
  output logic signed [WEIGHT_W-1:0] dend_weight,
  output logic                       dend_vld,
  input  logic                       dend_rdy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SYN_ADDR_W-1:0] cur_q, cur_d;
  logic [SYN_ADDR_W-1:0] end_q, end_d;
  logic [SYN_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [NEURON_W-1:0]   stg_tgt_q, stg_tgt_d;
  logic                  rdy_en_q, rdy_en_d;
  logic                  rv_q, rv_d;
  logic                  sv_q, sv_d;
  syn_entry_t            sk_q, sk_d;
  logic                  step_done_q, step_done_d;
  logic                  clear_done_q, clear_done_d;

  logic                  rd_en_c;
  logic                  wr_en_c;
  logic [SYN_ADDR_W-1:0] wr_addr_c;
  syn_entry_t            wr_data_c;
  logic [SYN_DATA_W-1:0] ram_rd_data;
  syn_entry_t            ram_rd;
  logic                  ram_keep_c;
  logic                  ram_live_c;
  logic                  ram_stuck_c;
  logic                  ram_to_skid_c;
  logic                  issue_c;
  logic                  cfg_unused_c;

  dp_ram_16x4096 u_table (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (SYN_DATA_W'(wr_data_c)),
    .rd_en   (rd_en_c),
    .rd_addr (cur_q),
    .rd_data (ram_rd_data)
  );

  assign ram_rd       = syn_entry_t'(ram_rd_data);
  assign cfg_unused_c = ^config_value[11:8];

`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  assign ram_keep_c = (ram_rd.weight != '0);
`else
  assign ram_keep_c = 1'b1;
`endif

  // Two-entry skid: RAM read register is the first slot, sk_q the second (older, shown first).
  assign ram_live_c    = rv_q & ram_keep_c;
  assign ram_stuck_c   = ram_live_c & sv_q & ~dend_rdy;
  assign ram_to_skid_c = ram_live_c & ((sv_q & dend_rdy) | (~sv_q & ~dend_rdy));
  assign issue_c       = (state_q == ST_RUN) & ~clear_config & ~ram_stuck_c;

  assign syn_rdy     = rdy_en_q & (state_q == ST_IDLE) & enable & ~clear_config;
  assign dend_vld    = sv_q | ram_live_c;
  assign dend_addr   = sv_q ? sk_q.target : (ram_live_c ? ram_rd.target : '0);
  assign dend_weight = sv_q ? sk_q.weight : (ram_live_c ? ram_rd.weight : '0);
  assign step_done   = step_done_q;
  assign clear_done  = clear_done_q;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    end_d        = end_q;
    clr_addr_d   = clr_addr_q;
    clear_done_d = clear_done_q;
    stg_tgt_d    = stg_tgt_q;
    rdy_en_d     = 1'b1;
    rd_en_c      = 1'b0;
    wr_en_c      = 1'b0;
    wr_addr_c    = config_addr;
    wr_data_c    = '0;

    sk_d = ram_to_skid_c ? ram_rd : sk_q;
    sv_d = ram_to_skid_c | (sv_q & ~dend_rdy);
    rv_d = issue_c | ram_stuck_c;

    case (state_q)
      ST_IDLE: begin
        if (clear_config) begin
          state_d      = ST_CLEAR;
          clr_addr_d   = '0;
          clear_done_d = 1'b0;
        end else if (syn_vld && syn_rdy) begin
          cur_d   = syn_start;
          end_d   = syn_end;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_config) begin
          state_d      = ST_CLEAR;
          clr_addr_d   = '0;
          clear_done_d = 1'b0;
        end else if (issue_c) begin
          rd_en_c = 1'b1;
          cur_d   = cur_q + SYN_ADDR_W'(1);
          if (cur_q == end_q) state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (!clear_config) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b0;
        end else if (!clear_done_q) begin
          wr_en_c   = 1'b1;
          wr_addr_c = clr_addr_q;
          if (clr_addr_q == SYN_ADDR_W'(SYN_COUNT - 1)) clear_done_d = 1'b1;
          else clr_addr_d = clr_addr_q + SYN_ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_config) begin
      sv_d = 1'b0;
      rv_d = 1'b0;
    end

    // Table loads share the write port; an active clear sweep wins.
    if (config_enable && (state_q != ST_RUN) && !wr_en_c) begin
      case (config_byte)
        CFG_BYTE_CLR:    stg_tgt_d = '0;
        CFG_BYTE_TARGET: stg_tgt_d = config_value[NEURON_W-1:0];
        CFG_BYTE_WEIGHT: begin
          wr_en_c          = 1'b1;
          wr_addr_c        = config_addr;
          wr_data_c.target = stg_tgt_q;
          wr_data_c.weight = config_value[WEIGHT_W-1:0];
        end
        default: ;
      endcase
    end

    step_done_d = (state_q == ST_IDLE) & ~sv_q & ~rv_q & ~syn_vld & ~clear_config & ~next_step;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      end_q        <= '0;
      clr_addr_q   <= '0;
      stg_tgt_q    <= '0;
      rdy_en_q     <= 1'b0;
      rv_q         <= 1'b0;
      sv_q         <= 1'b0;
      sk_q         <= '0;
      step_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      clr_addr_q   <= clr_addr_d;
      stg_tgt_q    <= stg_tgt_d;
      rdy_en_q     <= rdy_en_d;
      rv_q         <= rv_d;
      sv_q         <= sv_d;
      sk_q         <= sk_d;
      step_done_q  <= step_done_d;
      clear_done_q <= clear_done_d;
    end
  end

endmodule

// File: doc/ucaspian_synapse.md
UCASPIAN_SYNAPSE -- requirements
Module: ucaspian_synapse

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low (asserted at 0).
REQ-003 SHALL have ports: enable in 1 run gate; clear_config in 1; clear_done out 1.
REQ-004 SHALL have ports: config_addr in 12, config_value in 12, config_byte in 3, config_enable in 1  synapse table load.
REQ-005 SHALL have ports: next_step in 1, step_done out 1  time sync.
REQ-006 SHALL have ports: syn_start in 12, syn_end in 12, syn_vld in 1, syn_rdy out 1  inclusive synapse range from axon.
REQ-007 SHALL have ports: dend_addr out 8, dend_weight out 8 (signed), dend_vld out 1, dend_rdy in 1  per-synapse charge to dendrite.

Function
REQ-008 SHALL hold a 4096x16 table: [15:8] target neuron, [7:0] signed weight; 1-cycle registered read.
REQ-009 SHALL use FSM IDLE, RUN, CLEAR; syn_rdy = 1 only in IDLE with enable=1 and clear_config=0.
REQ-010 SHALL, on syn_vld&&syn_rdy in IDLE, latch start/end, set cur=start, go RUN.
REQ-011 SHALL, in RUN, issue one read per cycle for cur when output slot is free or being drained; cur increments mod 4096.
REQ-012 SHALL treat range length as (end-start+1) mod 4096, 0 meaning 4096; end<start wraps 4095->0.
REQ-013 SHALL return to IDLE the cycle after issuing the read of cur==end; range accepted in cycle N yields first dend_vld in N+2.
REQ-014 SHALL sustain one dend transfer per cycle while dend_rdy=1; 2-entry skid so no entry is lost or duplicated when dend_rdy drops.
REQ-015 SHALL hold dend_addr/dend_weight stable while dend_vld=1 and dend_rdy=0.
REQ-016 SHALL accept config writes only when not in RUN: byte 1 clears staging, byte 2 sets target=value[7:0], byte 3 sets weight=value[7:0] and writes staging to config_addr.
REQ-017 SHALL, on clear_config (any state), abort RUN, flush skid, drop dend_vld, go CLEAR, write 0 to addresses 0..4095 one per cycle.
REQ-018 SHALL assert clear_done registered after address 4095 is written, held while clear_config=1; deassert clear_config returns to IDLE.
REQ-019 SHALL register step_done = IDLE && skid empty && !syn_vld && !clear_config; next_step forces step_done=0 for one cycle.
REQ-020 SHALL, with enable=0, finish an in-flight range but accept no new range.

Reset
REQ-021 SHALL on reset=0 immediately: state IDLE, cur 0, skid empty, dend_vld 0, dend_addr 0, dend_weight 0, step_done 0, clear_done 0, syn_rdy 0 until reset released.
REQ-022 SHALL not clear table contents on reset; only clear_config clears it.
REQ-023 SHALL discard a range in progress when reset asserts mid-RUN.

Configuration
REQ-024 SHALL honour macro UCASPIAN_SYN_SKIP_ZERO_EN: defined -> entries with weight 0 are read but never emitted on dend; undefined -> all entries emitted.
REQ-025 SHALL keep REQ-013 range-end timing independent of the macro; skipping only removes dend transfers.

Structure
REQ-026 SHALL place SYN_COUNT=4096, SYN_ADDR_W=12, NEURON_W=8, WEIGHT_W=8 and a packed syn_entry_t {target, weight} in shared package ucaspian_pkg.
REQ-027 SHALL instantiate table as sub-module dp_ram_16x4096 (same port set as existing dp_ram blocks).
REQ-028 SHALL keep FSM, counter and skid in this module; size 120-400 RTL lines.

Verification
REQ-029 SHALL cover: load 10:(t=5,w=3), 11:(t=7,w=-2), 12:(t=9,w=1); range 10..12, dend_rdy=1 -> (5,3),(7,-2),(9,1) on cycles N+2..N+4.
REQ-030 SHALL cover: same range, dend_rdy low cycles N+3..N+5 -> three transfers total, order kept, outputs stable while stalled.
REQ-031 SHALL cover: range 4094..1 -> four transfers, addresses 4094,4095,0,1.
REQ-032 SHALL cover: entry 11 weight 0 -> two transfers with UCASPIAN_SYN_SKIP_ZERO_EN, three without.
REQ-033 SHALL cover: clear_config mid-range -> dend_vld 0 next cycle, clear_done after 4096 writes, subsequent reads return (0,0).
REQ-034 SHALL cover: reset=0 pulse mid-range -> all outputs 0 asynchronously, syn_rdy 1 after release, step_done 1 within 2 cycles.
